// File: rtl/inv_bist.sv
// Built-in self-test sequencer for a bank of WIDTH inverter cells.
// Walks NUM_PAT counting patterns onto the cells' inputs and holds each one
// for SETTLE_CYC cycles. It then samples the cells' outputs against the
// lane-wise inverse of the driven value. It keeps a saturating count of bad
// patterns and the index of the first bad pattern. At the end of a run it
// reports pass/fail.
module inv_bist #(
  parameter int WIDTH      = 4,
  parameter int NUM_PAT    = 16,
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 8,
  localparam int IDX_W     = (NUM_PAT > 2) ? $clog2(NUM_PAT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] drv,
  input  logic [WIDTH-1:0] obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_seen,
  output logic [IDX_W-1:0] first_fail_idx
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] drv_q, drv_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_q, fail_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mismatch;

  // The pattern is the pattern index taken modulo 2^WIDTH. The sized cast
  // truncates when the index is wider than the bank. It zero-extends when
  // the index is narrower.
  function automatic logic [WIDTH-1:0] patternOf(input logic [IDX_W-1:0] k);
    return WIDTH'(k);
  endfunction

  // A pattern is bad if any lane fails to invert the value driven onto it.
  assign mismatch = (obs != ~drv_q);

  // State and result registers, cleared immediately by reset even mid-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      drv_q   <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      ffi_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Sequencing and checking: accept start, hold each pattern for the settle
  // window, then judge it and either step to the next pattern or finish.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    err_d   = err_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d   = '0;
          drv_d   = patternOf('0);
          cnt_d   = CNT_INIT;
          err_d   = '0;
          fail_d  = 1'b0;
          ffi_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!fail_q) begin
            fail_d = 1'b1;
            ffi_d  = idx_q;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = !(fail_q || mismatch);
        end else begin
          idx_d   = idx_q + 1'b1;
          drv_d   = patternOf(idx_q + 1'b1);
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy           = (state_q == SETTLE) || (state_q == CHECK);
  assign drv            = drv_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_seen      = fail_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_inv_bist.sv
// Self-checking bench for inv_bist.
// A behavioural inverter bank can be switched between healthy, broken,
// stuck-lane and glitchy behaviour. A second instance with a 3-bit error
// counter always sees a broken bank, which exercises saturation.
module tb_inv_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] drv;
  logic [3:0] obs;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] errCount;
  logic       failSeen;
  logic [3:0] firstFailIdx;

  logic [3:0] drv2;
  logic       busy2;
  logic       done2;
  logic       pass2;
  logic [2:0] errCount2;
  logic       failSeen2;
  logic [3:0] firstFailIdx2;

  int   mode;
  logic glitch;
  int   errors;
  int   checks;

  typedef struct {
    int   mode;
    logic expPass;
    int   expErr;
    logic expFail;
    int   expIdx;
  } vec_t;

  vec_t vecs[5];

  inv_bist #(.WIDTH(4), .NUM_PAT(16), .SETTLE_CYC(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .drv(drv), .obs(obs),
    .busy(busy), .done(done), .pass(pass), .err_count(errCount),
    .fail_seen(failSeen), .first_fail_idx(firstFailIdx)
  );

  inv_bist #(.WIDTH(4), .NUM_PAT(16), .SETTLE_CYC(2), .ERR_W(3)) dutSat (
    .clk(clk), .rst_n(rst_n), .start(start), .drv(drv2), .obs(drv2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(errCount2),
    .fail_seen(failSeen2), .first_fail_idx(firstFailIdx2)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural inverter bank.
  // 0 healthy, 1 no inversion, 2 lane 2 stuck low, 3 lane 3 stuck high,
  // 4 healthy but corrupted while the sequencer is settling.
  always_comb begin
    obs = ~drv;
    case (mode)
      1: obs = drv;
      2: obs = {~drv[3], 1'b0, ~drv[1:0]};
      3: obs = {1'b1, ~drv[2:0]};
      4: obs = ~drv ^ (glitch ? 4'hF : 4'h0);
      default: obs = ~drv;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulses start and follows the run until done, with a bounded wait.
  // Optionally pulses start a second time after cycle extraAt. It returns
  // the edge count to done, the number of busy cycles, and the number of
  // cycles where drv differed from the pattern expected in that cycle.
  task automatic applyStimulus(input int extraAt, output int cyc,
                               output int busyCnt, output int drvBad);
    int expDrv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cyc     = 0;
    busyCnt = busy ? 1 : 0;
    drvBad  = (drv !== 4'h0) ? 1 : 0;
    glitch  = 1'b1;
    while (!done && cyc < 200) begin
      if (cyc == extraAt) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      glitch = ((cyc % 3) != 2);
      if (busy) busyCnt++;
      expDrv = (cyc < 48) ? (cyc / 3) : 15;
      if (drv !== 4'(expDrv)) drvBad++;
    end
    glitch = 1'b0;
  endtask

  // Compares every result output with its expected value.
  task automatic checkResults(input string tag, input logic ePass, input int eErr,
                              input logic eFail, input int eIdx);
    checkOutput({tag, ".done"},           int'(done),         1);
    checkOutput({tag, ".busy"},           int'(busy),         0);
    checkOutput({tag, ".pass"},           int'(pass),         int'(ePass));
    checkOutput({tag, ".err_count"},      int'(errCount),     eErr);
    checkOutput({tag, ".fail_seen"},      int'(failSeen),     int'(eFail));
    checkOutput({tag, ".first_fail_idx"}, int'(firstFailIdx), eIdx);
  endtask

  initial begin
    int cyc;
    int busyCnt;
    int drvBad;
    string tag;

    errors = 0;
    checks = 0;
    mode   = 0;
    glitch = 1'b0;
    start  = 1'b0;
    rst_n  = 1'b0;

    vecs[0] = '{mode: 0, expPass: 1'b1, expErr: 0,  expFail: 1'b0, expIdx: 0};
    vecs[1] = '{mode: 1, expPass: 1'b0, expErr: 16, expFail: 1'b1, expIdx: 0};
    vecs[2] = '{mode: 2, expPass: 1'b0, expErr: 8,  expFail: 1'b1, expIdx: 0};
    vecs[3] = '{mode: 3, expPass: 1'b0, expErr: 8,  expFail: 1'b1, expIdx: 8};
    vecs[4] = '{mode: 4, expPass: 1'b1, expErr: 0,  expFail: 1'b0, expIdx: 0};

    #3;
    checkOutput("reset.drv",  int'(drv),      0);
    checkOutput("reset.busy", int'(busy),     0);
    checkOutput("reset.done", int'(done),     0);
    checkOutput("reset.pass", int'(pass),     0);
    checkOutput("reset.err",  int'(errCount), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven runs.
    for (int i = 0; i < 5; i++) begin
      tag  = $sformatf("vec%0d", i);
      mode = vecs[i].mode;
      applyStimulus(-1, cyc, busyCnt, drvBad);
      checkOutput({tag, ".latency"}, cyc,     48);
      checkOutput({tag, ".busyCyc"}, busyCnt, 48);
      checkOutput({tag, ".drvSeq"},  drvBad,  0);
      checkResults(tag, vecs[i].expPass, vecs[i].expErr, vecs[i].expFail, vecs[i].expIdx);
    end

    // The 3-bit counter instance saturates on a fully broken bank.
    checkOutput("sat.done", int'(done2),     1);
    checkOutput("sat.err",  int'(errCount2), 7);
    checkOutput("sat.pass", int'(pass2),     0);

    // Reset in the middle of a broken run.
    mode  = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midrun.errBefore", int'(errCount), 6);
    checkOutput("midrun.busy",      int'(busy),     1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun.rst.drv",  int'(drv),          0);
    checkOutput("midrun.rst.busy", int'(busy),         0);
    checkOutput("midrun.rst.err",  int'(errCount),     0);
    checkOutput("midrun.rst.fail", int'(failSeen),     0);
    checkOutput("midrun.rst.ffi",  int'(firstFailIdx), 0);
    checkOutput("midrun.rst.done", int'(done),         0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode  = 0;
    @(posedge clk);
    #1;
    applyStimulus(-1, cyc, busyCnt, drvBad);
    checkOutput("afterRst.latency", cyc, 48);
    checkResults("afterRst", 1'b1, 0, 1'b0, 0);

    // start while busy is ignored.
    applyStimulus(10, cyc, busyCnt, drvBad);
    checkOutput("busyStart.latency", cyc,     48);
    checkOutput("busyStart.drvSeq",  drvBad,  0);
    checkOutput("busyStart.busyCyc", busyCnt, 48);

    // start in DONE clears the results and begins a new run.
    mode = 1;
    applyStimulus(-1, cyc, busyCnt, drvBad);
    checkOutput("doneStart.prevErr", int'(errCount), 16);
    mode  = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("doneStart.done", int'(done),     0);
    checkOutput("doneStart.err",  int'(errCount), 0);
    checkOutput("doneStart.fail", int'(failSeen), 0);
    checkOutput("doneStart.busy", int'(busy),     1);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("doneStart.latency", cyc, 48);
    checkResults("doneStart", 1'b1, 0, 1'b0, 0);

    // DONE holds its results indefinitely without start.
    repeat (10) @(posedge clk);
    #1;
    checkResults("hold", 1'b1, 0, 1'b0, 0);
    checkOutput("hold.drv", int'(drv), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_bist.md
Name: inv_bist

Overview:
- Synthesizable built-in self-test sequencer for a bank of WIDTH inverter cells (the `neg` primitive, a->c).
- It drives stimulus into the cells' inputs, waits a settle window, samples the cells' outputs and checks each lane against the inverse of what it drove.
- It accumulates a saturating error count and reports pass/fail with the index of the first failing pattern.
- It sits beside the inverter bank and replaces the hand-written stimulus/display benches with an on-chip checker.

Parameters:
- WIDTH, 4, number of inverter lanes driven and checked in parallel (>=1).
- NUM_PAT, 16, number of patterns applied per run (>=2).
- SETTLE_CYC, 2, cycles each pattern is held before sampling (>=1).
- ERR_W, 8, width of error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- drv  output  WIDTH  stimulus to inverter inputs (a).
- obs  input  WIDTH  inverter outputs (c) returned to checker.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE until the next start.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  ERR_W  number of mismatching patterns, saturating at 2^ERR_W-1.
- fail_seen  output  1  set on the first mismatch of a run.
- first_fail_idx  output  IDX_W  pattern index of the first mismatch; IDX_W = max(1, clog2(NUM_PAT)).

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately, any state, including mid-run): state=IDLE; drv=0, busy=0, done=0, pass=0, err_count=0, fail_seen=0, first_fail_idx=0, internal idx=0, settle counter=0.
- Pattern rule: pattern(k) = k mod 2^WIDTH, zero-extended to WIDTH. Expected obs = ~pattern(k), lane-wise.
- States: IDLE, SETTLE, CHECK, DONE. busy=1 exactly in SETTLE and CHECK.
- IDLE or DONE with start=1:
  - idx<=0, drv<=pattern(0), settle cnt<=SETTLE_CYC-1.
  - err_count<=0, fail_seen<=0, first_fail_idx<=0, done<=0, pass<=0.
  - Next state SETTLE.
- SETTLE: if cnt==0 go to CHECK, else cnt<=cnt-1. drv is held constant.
- CHECK (obs sampled this cycle):
  - A mismatch is any lane where obs != ~drv. One mismatching pattern adds exactly 1 to err_count, regardless of how many lanes fail. err_count holds at its max instead of wrapping.
  - On the first mismatch of a run: fail_seen<=1 and first_fail_idx<=idx. Later mismatches leave both unchanged.
  - If idx==NUM_PAT-1: go to DONE, done<=1, pass<=(no mismatch in the whole run, including this cycle). drv holds its last value.
  - Otherwise: idx<=idx+1, drv<=pattern(idx+1), cnt<=SETTLE_CYC-1, go to SETTLE.
- Latency:
  - Each pattern occupies exactly SETTLE_CYC+1 cycles.
  - done rises NUM_PAT*(SETTLE_CYC+1) rising edges after the edge that sampled start.
  - drv changes only on the edge leaving CHECK or the edge that accepts start.
- start while busy: ignored; the run is not restarted.
- start in DONE: a new run begins. Result outputs clear on that edge.
- DONE persists indefinitely without start. done, pass, err_count, fail_seen and first_fail_idx are stable throughout DONE.
- obs is only compared in CHECK. obs glitches during SETTLE have no effect.
- Wrap-around: when NUM_PAT > 2^WIDTH, patterns repeat modulo 2^WIDTH; idx itself never wraps within a run.

Test Plan:
- Good bank (WIDTH=4, NUM_PAT=16, SETTLE_CYC=2; obs=~drv through 4 `neg` instances); pulse start:
  - drv steps 0x0..0xF, each held 3 cycles.
  - busy=1 for 48 cycles; done=1 at edge 48.
  - pass=1, err_count=0, fail_seen=0.
- Broken bank (obs=drv, no inversion), same parameters -> pass=0, err_count=16, first_fail_idx=0.
- Stuck lane (obs[2] tied 0, other lanes inverted) -> failures on patterns with drv[2]=0 (0,1,2,3,8,9,10,11): err_count=8, first_fail_idx=0.
- Saturation (ERR_W=3, broken bank) -> err_count stops at 7, pass=0.
- Reset mid-run (rst_n low at cycle 20) -> outputs immediately 0 and state IDLE. After release, start gives a clean 48-cycle run with pass=1.
- start pulsed during busy at cycle 10 -> ignored, done still at cycle 48. start in DONE -> done drops next cycle and a new run begins with err_count=0.
